sha_round_seq: RTL and testbench



---
 rtl/sha_round_seq.sv | 172 +++++++++++++++++
 tb/tb_sha_round_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_round_seq.sv
// sha_round_seq: drives an external single-round SHA-256 datapath through
// ROUNDS rounds of one 512-bit block. It then adds the chaining midstate to
// the final working state.
//   clk, reset          : clock; synchronous active-high reset
//   start               : job request, accepted only while idle
//   midstate_i, block_i : chaining value H0..H7 and message block (word 0 in MSBs)
//   busy, done, err     : job in flight / end-of-block pulse / watchdog abort flag
//   digest_o            : midstate + final working state, held until next done
//   rnd_en, rnd_state_o,
//   rnd_k, rnd_w        : round issue pulse, working state a..h, K[t], W[t]
//   rnd_state_i,
//   rnd_valid           : next state from the round unit and its strobe
module sha_round_seq #(
   parameter int ROUNDS  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] midstate_i,
   input  logic [511:0] block_i,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [255:0] digest_o,
   output logic         rnd_en,
   output logic [255:0] rnd_state_o,
   output logic [31:0]  rnd_k,
   output logic [31:0]  rnd_w,
   input  logic [255:0] rnd_state_i,
   input  logic         rnd_valid
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINAL, S_DONE} state_t;

   localparam int WDW = $clog2(TIMEOUT + 1);

   localparam logic [0:63][31:0] K_ROM = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_t              state_q, state_d;
   logic [5:0]          t_q, t_d;
   logic [WDW-1:0]      wdog_q, wdog_d;
   logic                err_q, err_d;
   logic [255:0]        ms_q, ms_d;
   logic [255:0]        work_q, work_d;
   logic [255:0]        digest_q, digest_d;
   logic [255:0]        st_out_q, st_out_d;
   logic [31:0]         k_out_q, k_out_d;
   logic [31:0]         w_out_q, w_out_d;
   // win_q[0] is always W[t]; the window slides by one word per issue.
   logic [15:0][31:0]   win_q, win_d;
   logic [31:0]         w_new;

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      ms_d     = ms_q;
      work_d   = work_q;
      digest_d = digest_q;
      st_out_d = st_out_q;
      k_out_d  = k_out_q;
      w_out_d  = w_out_q;
      win_d    = win_q;
      // W[t+16], pushed in while W[t] is issued. Words produced in the
      // last 16 rounds are never used, which is harmless.
      w_new    = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ms_d   = midstate_i;
               work_d = midstate_i;
               for (int i = 0; i < 16; i++) win_d[i] = block_i[511-32*i -: 32];
               t_d     = '0;
               err_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            st_out_d = work_q;
            k_out_d  = K_ROM[t_q];
            w_out_d  = win_q[0];
            win_d    = {w_new, win_q[15:1]};
            wdog_d   = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (rnd_valid) begin
               work_d = rnd_state_i;
               if (t_q == 6'(ROUNDS - 1)) begin
                  state_d = S_FINAL;
               end else begin
                  t_d     = t_q + 6'd1;
                  state_d = S_ISSUE;
               end
            end else if (wdog_q == WDW'(TIMEOUT - 2)) begin
               // Abort here so done lands exactly TIMEOUT cycles after rnd_en;
               // a strobe arriving in this same cycle still wins.
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_FINAL: begin
            for (int i = 0; i < 8; i++)
               digest_d[32*i +: 32] = ms_q[32*i +: 32] + work_q[32*i +: 32];
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         t_q      <= '0;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         ms_q     <= '0;
         work_q   <= '0;
         digest_q <= '0;
         st_out_q <= '0;
         k_out_q  <= '0;
         w_out_q  <= '0;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
         ms_q     <= ms_d;
         work_q   <= work_d;
         digest_q <= digest_d;
         st_out_q <= st_out_d;
         k_out_q  <= k_out_d;
         w_out_q  <= w_out_d;
         win_q    <= win_d;
      end
   end

   // Issue values are shown live during ISSUE and held afterwards.
   assign rnd_en      = (state_q == S_ISSUE);
   assign rnd_state_o = rnd_en ? work_q      : st_out_q;
   assign rnd_k       = rnd_en ? K_ROM[t_q]  : k_out_q;
   assign rnd_w       = rnd_en ? win_q[0]    : w_out_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign digest_o    = digest_q;

endmodule

// File: tb/tb_sha_round_seq.sv
module tb_sha_round_seq;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
   localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [255:0] midstate_i;
   logic [511:0] block_i;
   logic         busy, done, err, rnd_en;
   logic [255:0] digest_o, rnd_state_o;
   logic [31:0]  rnd_k, rnd_w;
   logic [255:0] rnd_state_i = '0;
   logic         rnd_valid = 1'b0;

   int tests = 0;
   int fails = 0;

   sha_round_seq #(.ROUNDS(64), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .midstate_i(midstate_i), .block_i(block_i),
      .busy(busy), .done(done), .err(err), .digest_o(digest_o),
      .rnd_en(rnd_en), .rnd_state_o(rnd_state_o), .rnd_k(rnd_k), .rnd_w(rnd_w),
      .rnd_state_i(rnd_state_i), .rnd_valid(rnd_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- round unit model ----------------
   int           lat = 1;
   int           drop_idx = -1;
   int           issue_cnt = 0;
   int           pend_cnt = 0;
   bit           pend_drop = 0;
   bit           stray = 0;
   logic [255:0] pend_state;
   logic [255:0] sseen0;
   logic [31:0]  kseen [64];
   logic [31:0]  wseen [64];
   int           issue_cyc [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   always @(negedge clk) begin
      rnd_valid = stray;
      if (stray) rnd_state_i = {8{$urandom}};
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0 && !pend_drop) begin
            rnd_valid   = 1'b1;
            rnd_state_i = pend_state;
         end
      end
      if (rnd_en === 1'b1) begin
         if (issue_cnt < 64) begin
            kseen[issue_cnt]     = rnd_k;
            wseen[issue_cnt]     = rnd_w;
            issue_cyc[issue_cnt] = cyc;
         end
         if (issue_cnt == 0) sseen0 = rnd_state_o;
         pend_state = sha_round(rnd_state_o, rnd_k, rnd_w);
         pend_cnt   = lat;
         pend_drop  = (issue_cnt == drop_idx);
         issue_cnt++;
      end
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic start_job(input logic [255:0] mid, input logic [511:0] blk);
      midstate_i = mid;
      block_i    = blk;
      start      = 1'b1;
      issue_cnt  = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // n = cycles from the accept edge to the done pulse, -1 if it never came
   task automatic wait_done(output int n);
      bool_loop: begin
         n = 1;
         for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) disable bool_loop;
         end
         n = -1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, err, rnd_en} !== 4'b0000) begin
         fails++; $display("FAIL reset_ctrl: busy/done/err/rnd_en=%b required 0000", {busy, done, err, rnd_en});
      end
      tests++;
      if (digest_o !== 256'h0) begin
         fails++; $display("FAIL reset_digest: got %h required 0", digest_o);
      end
      tests++;
      if ({rnd_state_o, rnd_k, rnd_w} !== 320'h0) begin
         fails++; $display("FAIL reset_issue: state=%h k=%h w=%h required 0", rnd_state_o, rnd_k, rnd_w);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_abc_l1;
      int n;
      logic [511:0] wcat;
      lat = 1;
      start_job(IV, ABC);
      wait_done(n);
      tests++;
      if (n !== 130) begin fails++; $display("FAIL l1_latency: got %0d cycles required 130", n); end
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL l1_err: got %b required 0", err); end
      tests++;
      if (digest_o !== ABC_DIG) begin fails++; $display("FAIL l1_digest: got %h required %h", digest_o, ABC_DIG); end
      tests++;
      if (issue_cnt !== 64) begin fails++; $display("FAIL l1_issues: got %0d required 64", issue_cnt); end
      tests++;
      if (sseen0 !== IV) begin fails++; $display("FAIL l1_state0: got %h required %h", sseen0, IV); end
      tests++;
      if (kseen[0] !== 32'h428a2f98) begin fails++; $display("FAIL k0: got %h required 428a2f98", kseen[0]); end
      tests++;
      if (kseen[63] !== 32'hc67178f2) begin fails++; $display("FAIL k63: got %h required c67178f2", kseen[63]); end
      for (int t = 0; t < 16; t++) wcat[511-32*t -: 32] = wseen[t];
      tests++;
      if (wcat !== ABC) begin fails++; $display("FAIL w0_15: got %h required %h", wcat, ABC); end
      tests++;
      if (wseen[16] !== 32'h61626380) begin fails++; $display("FAIL w16: got %h required 61626380", wseen[16]); end
      @(posedge clk); #1;
      tests++;
      if ({busy, done} !== 2'b00) begin fails++; $display("FAIL l1_after_done: busy/done=%b required 00", {busy, done}); end
   endtask

   task automatic test_abc_l3;
      int n;
      lat = 3;
      start_job(IV, ABC);
      wait_done(n);
      tests++;
      if (n !== 258) begin fails++; $display("FAIL l3_latency: got %0d cycles required 258", n); end
      tests++;
      if (digest_o !== ABC_DIG) begin fails++; $display("FAIL l3_digest: got %h required %h", digest_o, ABC_DIG); end
      tests++;
      if (issue_cnt !== 64) begin fails++; $display("FAIL l3_issues: got %0d required 64", issue_cnt); end
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL l3_err: got %b required 0", err); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_timeout;
      int n;
      lat = 1;
      drop_idx = 5;
      start_job(IV, ~ABC);
      wait_done(n);
      tests++;
      if (err !== 1'b1) begin fails++; $display("FAIL to_err: got %b required 1", err); end
      tests++;
      if (issue_cnt !== 6) begin fails++; $display("FAIL to_issues: got %0d required 6", issue_cnt); end
      tests++;
      if (n < 0 || cyc - issue_cyc[5] !== 16) begin
         fails++; $display("FAIL to_delay: got %0d cycles after 6th rnd_en required 16", cyc - issue_cyc[5]);
      end
      tests++;
      if (digest_o !== ABC_DIG) begin fails++; $display("FAIL to_digest_held: got %h required %h", digest_o, ABC_DIG); end
      drop_idx = -1;
      repeat (3) @(posedge clk);
      #1;
      start_job(IV, ABC);
      tests++;
      if ({busy, err} !== 2'b10) begin fails++; $display("FAIL to_err_clear: busy/err=%b required 10", {busy, err}); end
      wait_done(n);
      tests++;
      if (n !== 130 || digest_o !== ABC_DIG || err !== 1'b0) begin
         fails++; $display("FAIL to_recover: cycles=%0d err=%b digest=%h required 130 0 %h", n, err, digest_o, ABC_DIG);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int n;
      lat = 1;
      midstate_i = IV;
      block_i    = ABC;
      start      = 1'b1;
      issue_cnt  = 0;
      @(posedge clk); #1;
      n = 1;
      for (int i = 0; i < 1000; i++) begin
         if (done === 1'b1) break;
         if (n == 10) begin midstate_i = ~IV; block_i = ~ABC; end
         if (n == 60) begin midstate_i = IV; block_i = ABC; end
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n !== 130 || digest_o !== ABC_DIG) begin
         fails++; $display("FAIL b2b_job1: cycles=%0d digest=%h required 130 %h", n, digest_o, ABC_DIG);
      end
      @(posedge clk); #1;
      tests++;
      if ({busy, rnd_en} !== 2'b00) begin fails++; $display("FAIL b2b_idle_gap: busy/rnd_en=%b required 00", {busy, rnd_en}); end
      @(posedge clk); #1;
      tests++;
      if ({busy, rnd_en} !== 2'b11) begin fails++; $display("FAIL b2b_reaccept: busy/rnd_en=%b required 11", {busy, rnd_en}); end
      start = 1'b0;
      wait_done(n);
      tests++;
      if (n !== 130 || digest_o !== ABC_DIG) begin
         fails++; $display("FAIL b2b_job2: cycles=%0d digest=%h required 130 %h", n, digest_o, ABC_DIG);
      end
      tests++;
      if (issue_cnt !== 128) begin fails++; $display("FAIL b2b_issues: got %0d required 128", issue_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int n;
      bit hit;
      bit bad;
      lat = 3;
      hit = 0;
      start_job(IV, ABC);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (issue_cnt == 31 && rnd_en === 1'b0) begin hit = 1; break; end
      end
      tests++;
      if (!hit) begin fails++; $display("FAIL rst_reach_r30: round 30 WAIT not reached, issues=%0d", issue_cnt); end
      reset = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({busy, done, err, rnd_en, digest_o, rnd_state_o, rnd_k, rnd_w} !== 580'h0) begin
         fails++; $display("FAIL rst_mid_vals: busy=%b done=%b err=%b en=%b digest=%h k=%h w=%h required all 0",
                           busy, done, err, rnd_en, digest_o, rnd_k, rnd_w);
      end
      reset = 1'b0;
      stray = 1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i == 2) stray = 0;
         if (busy !== 1'b0 || done !== 1'b0) bad = 1;
      end
      tests++;
      if (bad) begin fails++; $display("FAIL rst_stray: busy/done seen after reset, required 0"); end
      lat = 1;
      start_job(IV, ABC);
      wait_done(n);
      tests++;
      if (n !== 130 || digest_o !== ABC_DIG) begin
         fails++; $display("FAIL rst_fresh_job: cycles=%0d digest=%h required 130 %h", n, digest_o, ABC_DIG);
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      midstate_i = '0;
      block_i    = '0;
      test_reset;
      test_abc_l1;
      test_abc_l3;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
